// File: rtl/md_unit.sv
// Multiply/divide unit with an architectural HI/LO register pair.
// The result is computed at accept and committed to HI/LO after a fixed latency.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_ZERO = CW'(0);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     res_hi_q;
    logic [WIDTH-1:0]     res_lo_q;
    logic                 commit_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 div_zero_q;

    logic                 arith_d;
    logic                 is_div_d;
    logic                 is_sdiv_d;
    logic                 dz_d;
    logic [CW-1:0]        lat_d;
    logic [2*WIDTH-1:0]   res_d;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   prod_s_d;
    logic [2*WIDTH-1:0]   prod_u_d;
    logic [WIDTH-1:0]     dvd_d;
    logic [WIDTH-1:0]     dvs_d;
    logic [WIDTH-1:0]     q_u_d;
    logic [WIDTH-1:0]     r_u_d;
    logic [WIDTH-1:0]     q_d;
    logic [WIDTH-1:0]     r_d;

    // Decode the op and compute the full result from operands and current HI/LO.
    always_comb begin
        arith_d   = (md_op >= OP_MULT) && (md_op <= OP_MSUBU);
        is_div_d  = (md_op == OP_DIV) || (md_op == OP_DIVU);
        is_sdiv_d = (md_op == OP_DIV);
        dz_d      = is_div_d && (b == ZERO_W);
        lat_d     = is_div_d ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        acc_d     = {hi_q, lo_q};
        prod_s_d  = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u_d  = {ZERO_W, a} * {ZERO_W, b};
        // Signed divide runs on magnitudes; a zero divisor is replaced so the
        // divider never sees zero (the result is discarded in that case).
        dvd_d = (is_sdiv_d && a[WIDTH-1]) ? (~a + ONE_W) : a;
        dvs_d = (b == ZERO_W) ? ONE_W :
                ((is_sdiv_d && b[WIDTH-1]) ? (~b + ONE_W) : b);
        q_u_d = dvd_d / dvs_d;
        r_u_d = dvd_d % dvs_d;
        q_d   = (is_sdiv_d && (a[WIDTH-1] ^ b[WIDTH-1])) ? (~q_u_d + ONE_W) : q_u_d;
        r_d   = (is_sdiv_d && a[WIDTH-1]) ? (~r_u_d + ONE_W) : r_u_d;
        case (md_op)
            OP_MULT:  res_d = prod_s_d;
            OP_MULTU: res_d = prod_u_d;
            OP_MADD:  res_d = acc_d + prod_s_d;
            OP_MADDU: res_d = acc_d + prod_u_d;
            OP_MSUB:  res_d = acc_d - prod_s_d;
            OP_MSUBU: res_d = acc_d - prod_u_d;
            OP_DIV:   res_d = {r_d, q_d};
            OP_DIVU:  res_d = {r_d, q_d};
            default:  res_d = acc_d;
        endcase
    end

    // IDLE/RUN control, latency counter and HI/LO commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_ZERO;
            res_hi_q   <= ZERO_W;
            res_lo_q   <= ZERO_W;
            commit_q   <= 1'b0;
            hi_q       <= ZERO_W;
            lo_q       <= ZERO_W;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            div_zero_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !cancel) begin
                        if (arith_d) begin
                            res_hi_q   <= res_d[2*WIDTH-1:WIDTH];
                            res_lo_q   <= res_d[WIDTH-1:0];
                            commit_q   <= !dz_d;
                            div_zero_q <= dz_d;
                            cnt_q      <= lat_d;
                            busy_q     <= 1'b1;
                            state_q    <= RUN;
                        end else if (md_op == OP_MTHI) begin
                            hi_q <= a;
                        end else if (md_op == OP_MTLO) begin
                            lo_q <= a;
                        end
                    end
                end
                RUN: begin
                    if (cancel) begin
                        cnt_q   <= CNT_ZERO;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_ONE) begin
                        if (commit_q) begin
                            hi_q <= res_hi_q;
                            lo_q <= res_lo_q;
                        end
                        cnt_q   <= CNT_ZERO;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    cnt_q   <= CNT_ZERO;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO register pair for the MIPS EX stage.
- Successor to the fixed 32-bit mult/div block.
- Adds configurable width and latencies, decoded op input, MADD/MADDU/MSUB/MSUBU accumulate modes, an exception-driven cancel, and a divide-by-zero flag.
- The pipeline stalls any HI/LO-dependent instruction while (start | busy).

Parameters:
WIDTH, 32, operand and HI/LO width.
MULT_CYCLES, 5, busy cycles for MULT/MULTU/MADD*/MSUB*; must be >= 1.
DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be >= 1.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  md_op is valid this cycle.
md_op  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO; all other codes are NOP.
a  input  WIDTH  rs operand.
b  input  WIDTH  rt operand.
cancel  input  1  exception flush; aborts an in-flight operation.
busy  output  1  operation in flight (registered).
hi  output  WIDTH  architectural HI.
lo  output  WIDTH  architectural LO.
div_zero  output  1  one-cycle pulse when DIV/DIVU with b==0 is accepted.

Behaviour:
- Reset: hi=0, lo=0, busy=0, div_zero=0, state IDLE, counter 0.
- Reset takes priority over every other input, including mid-operation; any in-flight result is discarded.
- States: IDLE, RUN.
- IDLE + start + !cancel + valid arithmetic op:
  - Latch result into internal res_hi/res_lo.
  - Load counter with the op latency.
  - Go to RUN; busy=1 from the next cycle.
- IDLE + start + MTHI: hi<=a at this edge; busy stays 0. MTLO does the same for lo.
- RUN: counter decrements each cycle. On the edge where counter==1:
  - hi<=res_hi, lo<=res_lo.
  - Go to IDLE; busy=0 on the following cycle.
  - busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles.
- start while busy is ignored, including MTHI/MTLO (the pipeline guarantees it does not happen). hi/lo are unaffected.
- cancel:
  - In RUN: return to IDLE next edge; busy=0 next cycle; hi/lo unchanged; result discarded.
  - In IDLE with start the same cycle: cancel wins; nothing accepted; MTHI/MTLO not written.
- Result computation (all arithmetic at 2*WIDTH, truncated):
  - MULT: {HI,LO} = signed(a)*signed(b).
  - MULTU: {HI,LO} = unsigned product.
  - MADD/MADDU: {HI,LO} = {hi,lo} + product (signed/unsigned product respectively). Uses hi/lo sampled at accept; wraps modulo 2^(2*WIDTH).
  - MSUB/MSUBU: {HI,LO} = {hi,lo} - product, with the same sampling and wrap rules.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of a.
  - DIV overflow case: a=most-negative, b=-1 → LO=most-negative, HI=0.
  - DIVU: unsigned quotient and remainder.
  - b==0 on DIV/DIVU: op is accepted and busy runs the full DIV_CYCLES; hi/lo are left unchanged at completion; div_zero pulses for the cycle after accept.
- hi/lo change only on: reset, MTHI/MTLO accept, or RUN completion. They are never written mid-operation.
- Outputs hi/lo are registers; there is no combinational bypass of an in-flight result.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7, b=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=-1 → lo=0x80000000, hi=0. DIVU a=7, b=0 → div_zero pulses one cycle, busy 10 cycles, hi/lo unchanged.
- MTHI a=0, MTLO a=0xFFFFFFFF, then MADDU a=1, b=1 → hi=1, lo=0. MSUB a=1, b=1 from hi=lo=0 → hi=lo=0xFFFFFFFF.
- MULT accepted, cancel at busy cycle 3 → busy low the next cycle; hi/lo keep prior values. start+MTHI with cancel the same cycle → hi unchanged.
- reset asserted during the 7th DIV cycle → hi=lo=0, busy=0 the next cycle. MTLO a=0x5 while busy is ignored.
- Instantiate WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=3. MULT a=0x8000, b=0x8000 → hi=0x4000, lo=0x0000 after 1 busy cycle. Back-to-back start the cycle busy falls is accepted.
